dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter_if.sv | 43 ++++
 rtl/dmem_arbiter.sv | 102 ++++++++++
 tb/tb_dmem_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage, the debug/loader port, the arbiter and the data RAM.
// The arbiter takes the slave view; whatever plays requesters and RAM takes the master view.
interface dmem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;

  logic        dbg_req;
  logic        dbg_we;
  logic        dbg_lock;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;

  logic [4:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output ram_addr, ram_we, ram_din,
    input  ram_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  ram_addr, ram_we, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port 32-word data RAM between the CPU MEM stage and the debug port.
// CPU has priority, a streak counter bounds debug starvation, and lock mode gives debug atomic ownership.
module dmem_arbiter #(
  parameter int STREAK   = 4,
  parameter int LOCK_MAX = 8
) (
  input logic          clock,
  input logic          resetn,
  dmem_arbiter_if.slave bus
);

  typedef enum logic {ARB, LOCK} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_t;

  state_t     r_state;
  owner_t     r_rdOwn;
  logic [3:0] r_streak;
  logic [3:0] r_lockCnt;

  logic w_dbgWin;
  logic w_cpuWin;
  logic w_streakFull;
  logic w_lockLast;
  logic w_unusedAddrBits;

  assign w_streakFull = (r_streak == 4'(STREAK));
  assign w_lockLast   = (r_lockCnt >= 4'(LOCK_MAX - 1));

  // Grants are forced off while reset is held so nothing reaches the RAM.
  always_comb begin
    w_dbgWin = 1'b0;
    w_cpuWin = 1'b0;
    if (resetn) begin
      if (r_state == LOCK) begin
        w_dbgWin = bus.dbg_req;
      end else begin
        w_dbgWin = bus.dbg_req & (~bus.cpu_req | w_streakFull);
        w_cpuWin = bus.cpu_req & ~w_dbgWin;
      end
    end
  end

  assign bus.cpu_stall  = bus.cpu_req & ~w_cpuWin;
  assign bus.dbg_gnt    = w_dbgWin;
  assign bus.ram_we     = (w_cpuWin & bus.cpu_we) | (w_dbgWin & bus.dbg_we);
  assign bus.ram_addr   = w_dbgWin ? bus.dbg_addr[6:2] : bus.cpu_addr[6:2];
  assign bus.ram_din    = w_dbgWin ? bus.dbg_wdata : bus.cpu_wdata;

  assign bus.cpu_rvalid = (r_rdOwn == OWN_CPU);
  assign bus.dbg_rvalid = (r_rdOwn == OWN_DBG);
  assign bus.cpu_rdata  = (r_rdOwn == OWN_CPU) ? bus.ram_dout : 32'd0;
  assign bus.dbg_rdata  = (r_rdOwn == OWN_DBG) ? bus.ram_dout : 32'd0;

  assign w_unusedAddrBits = ^{bus.cpu_addr[31:7], bus.cpu_addr[1:0],
                              bus.dbg_addr[31:7], bus.dbg_addr[1:0]};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ARB;
      r_streak  <= 4'd0;
      r_lockCnt <= 4'd0;
      r_rdOwn   <= OWN_NONE;
    end else begin
      if (w_cpuWin && !bus.cpu_we) begin
        r_rdOwn <= OWN_CPU;
      end else if (w_dbgWin && !bus.dbg_we) begin
        r_rdOwn <= OWN_DBG;
      end else begin
        r_rdOwn <= OWN_NONE;
      end

      if (w_dbgWin || !bus.dbg_req) begin
        r_streak <= 4'd0;
      end else if (w_cpuWin && !w_streakFull) begin
        r_streak <= r_streak + 4'd1;
      end

      // In LOCK a pending debug request is always granted, so dbg_req alone implies a grant here.
      case (r_state)
        ARB: begin
          if (w_dbgWin && bus.dbg_lock && (LOCK_MAX > 1)) begin
            r_state   <= LOCK;
            r_lockCnt <= 4'd1;
          end
        end
        LOCK: begin
          if (!bus.dbg_req || !bus.dbg_lock || w_lockLast) begin
            r_state   <= ARB;
            r_lockCnt <= 4'd0;
            r_streak  <= 4'd0;
          end else begin
            r_lockCnt <= r_lockCnt + 4'd1;
          end
        end
        default: begin
          r_state <= ARB;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run,
// all compared against a behavioural model of the arbitration rules and a shadow memory.
module tb_dmem_arbiter;

  localparam int STREAK   = 4;
  localparam int LOCK_MAX = 8;

  logic clock = 1'b0;
  logic resetn;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .STREAK  (STREAK),
    .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // Data RAM stand-in: synchronous write, read data valid the cycle after the address edge.
  logic [31:0] ramMem [32] = '{default: 32'h0};
  always @(posedge clock) begin
    if (bus.ram_we) ramMem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= ramMem[bus.ram_addr];
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          mStreak;
  bit          mLocked;
  int          mLockCount;
  int          mOwn;
  logic [31:0] mRdata;
  logic [31:0] shadow [32];
  bit          mCpuGnt;
  bit          mDbgGnt;

  // Observed values from the last cycle, for directed checks
  logic        obsStall;
  logic        obsDbgGnt;
  logic [4:0]  obsAddr;
  logic        obsCpuRvalid;
  logic [31:0] obsCpuRdata;
  logic        obsDbgRvalid;
  logic [31:0] obsDbgRdata;

  task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic cReq, input logic cWe, input logic [31:0] cAddr,
                               input logic [31:0] cData, input logic dReq, input logic dWe,
                               input logic dLock, input logic [31:0] dAddr, input logic [31:0] dData);
    bus.cpu_req   = cReq;
    bus.cpu_we    = cWe;
    bus.cpu_addr  = cAddr;
    bus.cpu_wdata = cData;
    bus.dbg_req   = dReq;
    bus.dbg_we    = dWe;
    bus.dbg_lock  = dLock;
    bus.dbg_addr  = dAddr;
    bus.dbg_wdata = dData;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // One full clock cycle: predict, compare, advance the model across the rising edge.
  task automatic checkOutput();
    logic       expWe;
    logic [4:0] expAddr;
    int         a;
    #2;
    if (mLocked) begin
      mDbgGnt = bus.dbg_req;
      mCpuGnt = 1'b0;
    end else begin
      mDbgGnt = bus.dbg_req && (!bus.cpu_req || mStreak == STREAK);
      mCpuGnt = bus.cpu_req && !mDbgGnt;
    end
    expWe   = (mCpuGnt && bus.cpu_we) || (mDbgGnt && bus.dbg_we);
    expAddr = mDbgGnt ? bus.dbg_addr[6:2] : bus.cpu_addr[6:2];

    obsStall     = bus.cpu_stall;
    obsDbgGnt    = bus.dbg_gnt;
    obsAddr      = bus.ram_addr;
    obsCpuRvalid = bus.cpu_rvalid;
    obsCpuRdata  = bus.cpu_rdata;
    obsDbgRvalid = bus.dbg_rvalid;
    obsDbgRdata  = bus.dbg_rdata;

    checkBit("cpu_stall", bus.cpu_stall, bus.cpu_req && !mCpuGnt);
    checkBit("dbg_gnt", bus.dbg_gnt, mDbgGnt);
    checkBit("ram_we", bus.ram_we, expWe);
    checkWord("ram_addr", 32'(bus.ram_addr), 32'(expAddr));
    if (expWe) checkWord("ram_din", bus.ram_din, mDbgGnt ? bus.dbg_wdata : bus.cpu_wdata);
    checkBit("cpu_rvalid", bus.cpu_rvalid, mOwn == 1);
    checkWord("cpu_rdata", bus.cpu_rdata, (mOwn == 1) ? mRdata : 32'd0);
    checkBit("dbg_rvalid", bus.dbg_rvalid, mOwn == 2);
    checkWord("dbg_rdata", bus.dbg_rdata, (mOwn == 2) ? mRdata : 32'd0);

    @(posedge clock);
    mOwn = 0;
    if (mCpuGnt) begin
      a = int'(bus.cpu_addr[6:2]);
      if (bus.cpu_we) shadow[a] = bus.cpu_wdata;
      else begin mOwn = 1; mRdata = shadow[a]; end
    end
    if (mDbgGnt) begin
      a = int'(bus.dbg_addr[6:2]);
      if (bus.dbg_we) shadow[a] = bus.dbg_wdata;
      else begin mOwn = 2; mRdata = shadow[a]; end
    end

    if (mDbgGnt || !bus.dbg_req) mStreak = 0;
    else if (mCpuGnt) mStreak++;

    if (!mLocked) begin
      if (mDbgGnt && bus.dbg_lock && LOCK_MAX > 1) begin
        mLocked    = 1'b1;
        mLockCount = 1;
      end
    end else if (!bus.dbg_req || !bus.dbg_lock) begin
      mLocked = 1'b0; mLockCount = 0; mStreak = 0;
    end else begin
      mLockCount++;
      if (mLockCount == LOCK_MAX) begin
        mLocked = 1'b0; mLockCount = 0; mStreak = 0;
      end
    end
    @(negedge clock);
  endtask

  // Called at a falling edge; asserts reset mid-cycle, checks the reset view, releases at the next falling edge.
  task automatic doReset();
    #1 resetn = 1'b0;
    #1;
    checkBit("rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
    checkBit("rst_dbg_rvalid", bus.dbg_rvalid, 1'b0);
    checkBit("rst_dbg_gnt", bus.dbg_gnt, 1'b0);
    checkBit("rst_ram_we", bus.ram_we, 1'b0);
    checkWord("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    checkWord("rst_dbg_rdata", bus.dbg_rdata, 32'd0);
    mStreak = 0; mLocked = 1'b0; mLockCount = 0; mOwn = 0;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    bit          cPend, dPend, cWe, dWe, dLock;
    logic [31:0] cAddr, cData, dAddr, dData;

    for (int i = 0; i < 32; i++) shadow[i] = 32'h0;
    resetn = 1'b0;
    applyIdle();
    @(negedge clock);
    bus.dbg_req = 1'b1;
    doReset();
    $display("[TB] reset released");

    // CPU write then read of word 5
    applyStimulus(1'b1, 1'b1, 32'h14, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput();
    checkBit("t1_wr_stall", obsStall, 1'b0);
    checkWord("t1_wr_addr", 32'(obsAddr), 32'd5);
    applyStimulus(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput();
    checkBit("t1_rd_stall", obsStall, 1'b0);
    applyIdle();
    checkOutput();
    checkBit("t1_rvalid", obsCpuRvalid, 1'b1);
    checkWord("t1_rdata", obsCpuRdata, 32'hDEADBEEF);

    // Both ports saturating: debug wins every fifth slot
    for (int k = 0; k < 15; k++) begin
      applyStimulus(1'b1, 1'b0, 32'(k * 4), 32'h0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
      checkOutput();
      checkBit("t2_dbg_gnt", obsDbgGnt, (k % 5) == 4);
      checkBit("t2_cpu_stall", obsStall, (k % 5) == 4);
    end

    // Debug alone: write then read word 2 with the CPU idle
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h08, 32'hCAFE0008);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h08, 32'h0);
    checkOutput();
    checkBit("t3_dbg_gnt", obsDbgGnt, 1'b1);
    checkWord("t3_ram_addr", 32'(obsAddr), 32'd2);
    applyIdle();
    checkOutput();
    checkBit("t3_dbg_rvalid", obsDbgRvalid, 1'b1);
    checkWord("t3_dbg_rdata", obsDbgRdata, 32'hCAFE0008);
    checkBit("t3_cpu_rvalid", obsCpuRvalid, 1'b0);

    // Lock held against a requesting CPU until the grant limit forces exit
    for (int k = 0; k < 13; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 1'b0, 1'b1, 32'h08, 32'h0);
      checkOutput();
      checkBit("t4_dbg_gnt", obsDbgGnt, k >= 4 && k <= 11);
      checkBit("t4_cpu_stall", obsStall, k >= 4 && k <= 11);
    end

    // Lock dropped on the third grant; CPU wins the following cycle
    applyIdle();
    checkOutput();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h11110001);
    checkOutput();
    checkBit("t5_gnt1", obsDbgGnt, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 1'b1, 1'b1, 32'h24, 32'h11110002);
    checkOutput();
    checkBit("t5_gnt2", obsDbgGnt, 1'b1);
    checkBit("t5_stall2", obsStall, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 1'b1, 1'b0, 32'h28, 32'h11110003);
    checkOutput();
    checkBit("t5_gnt3", obsDbgGnt, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 1'b1, 1'b0, 32'h2C, 32'h11110004);
    checkOutput();
    checkBit("t5_cpu_after", obsStall, 1'b0);
    checkBit("t5_dbg_after", obsDbgGnt, 1'b0);

    // Reset right after a CPU read grant drops the return
    applyStimulus(1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 1'b0, 1'b0, 32'h08, 32'h0);
    checkOutput();
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput();
    checkBit("t6_post_stall", obsStall, 1'b0);
    applyIdle();
    checkOutput();
    checkBit("t6_post_rvalid", obsCpuRvalid, 1'b1);
    checkWord("t6_post_rdata", obsCpuRdata, 32'hDEADBEEF);

    // Randomized traffic; requesters hold their request until the model says it was granted
    cPend = 1'b0; dPend = 1'b0; dLock = 1'b0;
    cWe = 1'b0; dWe = 1'b0; cAddr = '0; dAddr = '0; cData = '0; dData = '0;
    for (int n = 0; n < 500; n++) begin
      if (!cPend && $urandom_range(0, 3) != 0) begin
        cPend = 1'b1;
        cWe   = 1'($urandom_range(0, 1));
        cAddr = $urandom & 32'h7F;
        cData = $urandom;
      end
      if (!dPend && $urandom_range(0, 2) != 0) begin
        dPend = 1'b1;
        dWe   = 1'($urandom_range(0, 1));
        dAddr = $urandom & 32'h7F;
        dData = $urandom;
        dLock = ($urandom_range(0, 3) != 0);
      end
      applyStimulus(cPend, cWe, cAddr, cData, dPend, dWe, dLock, dAddr, dData);
      checkOutput();
      if (mCpuGnt) cPend = 1'b0;
      if (mDbgGnt) dPend = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
